// File: rtl/rs_gf_pkg.sv
// rtl/rs_gf_pkg.sv - GF(256) field constants, Chien state encoding and alpha-power multiply helper
package rs_gf_pkg;

  localparam int SYM_W = 8;
  localparam logic [SYM_W-1:0] GF_PRIM = 8'h1D;
  localparam int RS_N = 255;
  localparam int RS_T = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EVAL = 2'd1,
    ST_DONE = 2'd2
  } chien_state_t;

  // sym * alpha^j: j successive xtime steps, each a left shift reduced by the primitive polynomial.
  // The loop has a fixed bound so a constant j unrolls into a pure XOR network.
  function automatic logic [SYM_W-1:0] gf_mul_alpha(input logic [SYM_W-1:0] sym, input int j);
    logic [SYM_W-1:0] acc;
    acc = sym;
    for (int i = 0; i < RS_T; i++) begin
      if (i < j) begin
        acc = {acc[SYM_W-2:0], 1'b0} ^ (acc[SYM_W-1] ? GF_PRIM : {SYM_W{1'b0}});
      end
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_gf_cmul_alpha.sv
// rtl/rs_gf_cmul_alpha.sv - combinational GF(256) multiply by the constant alpha^J
module rs_gf_cmul_alpha
  import rs_gf_pkg::*;
#(
  parameter int J = 1
) (
  input  logic [SYM_W-1:0] sym_in,
  output logic [SYM_W-1:0] sym_out
);

  // Constant multiplier; collapses to a fixed XOR network for the given J.
  always_comb sym_out = gf_mul_alpha(sym_in, J);

endmodule

// File: rtl/rs_chien_search.sv
// rtl/rs_chien_search.sv - Chien search over alpha^1..alpha^255 with fixed 256-clock latency
module rs_chien_search
  import rs_gf_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             L_ready,
  input  logic [SYM_W-1:0] L1,
  input  logic [SYM_W-1:0] L2,
  input  logic [SYM_W-1:0] L3,
  input  logic [SYM_W-1:0] L4,
  input  logic [SYM_W-1:0] L5,
  input  logic [SYM_W-1:0] L6,
  input  logic [SYM_W-1:0] L7,
  input  logic [SYM_W-1:0] L8,
  output logic             loc_valid,
  output logic [SYM_W-1:0] loc_pos,
  output logic             done,
  output logic [3:0]       err_cnt,
  output logic [3:0]       lambda_deg,
  output logic             fail
);

  chien_state_t state, state_nxt;

  logic [SYM_W-1:0] l_vec   [RS_T];
  logic [SYM_W-1:0] g_q     [RS_T];
  logic [SYM_W-1:0] g_nxt   [RS_T];
  logic [SYM_W-1:0] mul_in  [RS_T];
  logic [SYM_W-1:0] mul_out [RS_T];

  logic [7:0]       k_q, k_nxt;
  logic [SYM_W-1:0] sum;
  logic [3:0]       deg_calc;
  logic             loc_valid_nxt, done_nxt, fail_nxt;
  logic [SYM_W-1:0] loc_pos_nxt;
  logic [3:0]       err_nxt, deg_nxt;

  assign l_vec[0] = L1;
  assign l_vec[1] = L2;
  assign l_vec[2] = L3;
  assign l_vec[3] = L4;
  assign l_vec[4] = L5;
  assign l_vec[5] = L6;
  assign l_vec[6] = L7;
  assign l_vec[7] = L8;

  // One multiplier bank serves both paths: premultiply L_j at load, step G_j during the search.
  always_comb begin
    for (int j = 0; j < RS_T; j++) begin
      mul_in[j] = (state == ST_IDLE) ? l_vec[j] : g_q[j];
    end
  end

  for (genvar j = 0; j < RS_T; j++) begin : g_cmul
    rs_gf_cmul_alpha #(.J(j + 1)) u_cmul (
      .sym_in  (mul_in[j]),
      .sym_out (mul_out[j])
    );
  end

  // Lambda(alpha^k) for the current k: implicit constant term plus all G_j terms.
  always_comb begin
    sum = 8'h01;
    for (int j = 0; j < RS_T; j++) begin
      sum = sum ^ g_q[j];
    end
  end

  // Degree of the incoming locator: highest nonzero coefficient index.
  always_comb begin
    deg_calc = 4'd0;
    for (int j = 0; j < RS_T; j++) begin
      if (l_vec[j] != '0) deg_calc = 4'(j + 1);
    end
  end

  // Next-state and next-output decode; L_ready outside IDLE falls through untouched.
  always_comb begin
    state_nxt     = state;
    g_nxt         = g_q;
    k_nxt         = k_q;
    loc_valid_nxt = 1'b0;
    loc_pos_nxt   = loc_pos;
    done_nxt      = 1'b0;
    err_nxt       = err_cnt;
    deg_nxt       = lambda_deg;
    fail_nxt      = fail;
    unique case (state)
      ST_IDLE: begin
        if (L_ready) begin
          g_nxt     = mul_out;
          k_nxt     = 8'd1;
          err_nxt   = 4'd0;
          deg_nxt   = deg_calc;
          state_nxt = ST_EVAL;
        end
      end
      ST_EVAL: begin
        if (sum == '0) begin
          loc_valid_nxt = 1'b1;
          loc_pos_nxt   = 8'(RS_N) - k_q;
          err_nxt       = err_cnt + 4'd1;
        end
        g_nxt = mul_out;
        k_nxt = k_q + 8'd1;
        if (k_q == 8'(RS_N)) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        done_nxt  = 1'b1;
        fail_nxt  = (err_cnt != lambda_deg);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset abandons any search in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Datapath and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int j = 0; j < RS_T; j++) g_q[j] <= '0;
      k_q        <= '0;
      loc_valid  <= 1'b0;
      loc_pos    <= '0;
      done       <= 1'b0;
      err_cnt    <= '0;
      lambda_deg <= '0;
      fail       <= 1'b0;
    end else begin
      for (int j = 0; j < RS_T; j++) g_q[j] <= g_nxt[j];
      k_q        <= k_nxt;
      loc_valid  <= loc_valid_nxt;
      loc_pos    <= loc_pos_nxt;
      done       <= done_nxt;
      err_cnt    <= err_nxt;
      lambda_deg <= deg_nxt;
      fail       <= fail_nxt;
    end
  end

endmodule

// File: doc/rs_chien_search.md
# rs_chien_search

Chien search stage of the RS(255,239) decoder, directly downstream of the Berlekamp-Massey lambda stage. It takes the error-locator coefficients L1..L8 when `L_ready` pulses and evaluates Λ(α^k) for k = 1..255 in one pass of 255 cycles. It emits one registered pulse per root, carrying the error position, and finishes with a summary carrying the root count and a failure flag. Timing is constant: every block takes exactly 256 clocks from `L_ready` to `done`, whatever its contents.

## Interface
Parameters:
- none. Field constants live in the shared package.

Ports:
- `clk`  in  1  system clock (56 MHz planned).
- `reset`  in  1  asynchronous, active-low reset.
- `L_ready`  in  1  one-clock pulse; L1..L8 are valid in the same cycle.
- `L1`..`L8`  in  8 each  lambda coefficients of x^1..x^8, GF(256) polynomial-basis ("decimal") format. Λ0 = 1 is implicit.
- `loc_valid`  out  1  one-clock pulse per root found.
- `loc_pos`  out  8  error position exponent p (0..254), where symbol p is the coefficient of x^p in the received polynomial. Valid only while `loc_valid` = 1.
- `done`  out  1  one-clock pulse at the end of the search.
- `err_cnt`  out  4  number of roots found. Valid while `done` = 1, held until the next `L_ready`.
- `lambda_deg`  out  4  degree of Λ (0..8), captured at load.
- `fail`  out  1  1 when `err_cnt` ≠ `lambda_deg`. Valid with `done` and held.

## Operation
- States: IDLE, EVAL, DONE.
- IDLE:
  - On `L_ready` = 1, load G_j <= L_j·α^j for j = 1..8, set k <= 1 and err_cnt <= 0.
  - Also set lambda_deg <= the highest j with L_j ≠ 0 (0 if all are zero).
  - Go to EVAL.
- EVAL, every cycle:
  - sum = 1 ^ G_1 ^ … ^ G_8, computed combinationally.
  - If sum == 0: loc_valid <= 1, loc_pos <= 255 − k, err_cnt <= err_cnt + 1. Otherwise loc_valid <= 0.
  - Update G_j <= G_j·α^j and k <= k + 1.
  - When k == 255, go to DONE after this evaluation.
- DONE:
  - loc_valid <= 0, done <= 1, fail <= (err_cnt ≠ lambda_deg).
  - Go to IDLE. done <= 0 on the following cycle.
- Arithmetic:
  - Field is GF(2^8) with primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), α = 0x02.
  - Multiplication by α^j uses a combinational constant multiplier; no log/antilog memories.
  - k is 8 bits. k = 255 maps to position 0 because α^255 = 1.
- Boundary conditions:
  - `L_ready` during EVAL or DONE is ignored; no restart and no error flag. Upstream constant timing (≥ 500 clocks per block) guarantees this does not occur in normal operation.
  - All-zero lambda: no roots, err_cnt = 0, lambda_deg = 0, fail = 0.
  - Repeated root: counted once, so fail = 1.
  - err_cnt never exceeds 8, because Λ has degree ≤ 8.
- Reset (`reset` = 0), at any time including mid-EVAL:
  - State goes to IDLE; G, k, loc_pos, err_cnt, lambda_deg are cleared to 0.
  - loc_valid = done = fail = 0.
  - Any search in progress is discarded and produces no `done`.

## Timing
- Edge numbering: `L_ready` is sampled at edge T.
- The evaluation for k happens at edge T+k, so `loc_valid` for that root is high during the cycle after edge T+k. The position reported is 255 − k.
- Positions are therefore reported in descending order, 254 down to 0.
- `done` is high during the cycle after edge T+256. This is a fixed latency of 256 clocks.
- The earliest next `L_ready` accepted is the cycle in which `done` is high. State is IDLE then.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package `rs_gf_pkg` holds:
  - GF_PRIM = 8'h1D, RS_N = 255, RS_T = 8, width constant SYM_W = 8;
  - state encoding;
  - function gf_mul_alpha(sym, j) returning sym·α^j.
- Sub-module `rs_gf_cmul_alpha` (parameter J) is an 8-bit combinational multiply by α^J.
  - Eight instances are used for the update path.
  - Eight more instances, or a mux with the update path, are used for the load premultiply.

## Test plan
- No errors: L1..L8 = 0 -> no `loc_valid` pulses; `done` exactly 256 clocks after `L_ready`; err_cnt = 0, lambda_deg = 0, fail = 0.
- Single error: L1 = 0x02, rest 0 -> exactly one pulse, loc_pos = 1, after edge T+254; err_cnt = 1, fail = 0.
- Two errors: L1 = 0x03, L2 = 0x02 (Λ = (1+x)(1+αx)) -> pulses with loc_pos = 1 at T+254 and loc_pos = 0 at T+255; err_cnt = 2, lambda_deg = 2, fail = 0.
- Repeated root: L2 = 0x01, rest 0 (Λ = (1+x)²) -> one pulse with loc_pos = 0; err_cnt = 1, lambda_deg = 2, fail = 1.
- Reset mid-search: assert `reset` low at T+100 of a two-error block -> all outputs 0 immediately and no `done`. Then release reset and apply a fresh single-error block -> correct result with no stale data.
- Back-to-back blocks: issue the next `L_ready` in the `done` cycle, plus one `L_ready` during EVAL -> the in-EVAL pulse is ignored; the second block completes normally 256 clocks after its accepted `L_ready`.
